x_uart_tx_arb: RTL

- Round-robin, message-locking arbiter that shares one UART transmitter among p_num_req byte sources.
- Sits directly in front of the UART TX. It drives that block's data/valid inputs and consumes its accept pulse. The UART pulses accept in the last cycle of the stop bit.
- A grant is held for a whole message (until last), a burst limit, or a hold timeout. An optional idle gap is inserted between messages.

---
 rtl/x_uart_pkg.sv | 18 +
 rtl/x_rr_pick.sv | 34 +++
 rtl/x_uart_tx_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/x_uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and byte type.
package x_uart_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    typedef logic [7:0] byte_t;

    // Round-robin successor of idx among n requesters.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/x_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module x_rr_pick #(
    parameter int p_n = 4,
    parameter int p_w = $clog2(p_n)
) (
    input  logic [p_n-1:0] i_req,
    input  logic [p_w-1:0] i_ptr,
    output logic           o_found,
    output logic [p_w-1:0] o_idx
);

    int w_best_dist;
    int w_dist;

    // Smallest forward distance from the pointer wins.
    always_comb begin
        o_found     = 1'b0;
        o_idx       = '0;
        w_best_dist = p_n;
        w_dist      = 0;
        for (int k = 0; k < p_n; k++) begin
            w_dist = k - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + p_n;
            end
            if (i_req[k] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_idx       = p_w'(k);
                o_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_uart_tx_arb.sv
// Message-locking round-robin arbiter feeding one UART transmitter from p_num_req byte sources.
module x_uart_tx_arb
    import x_uart_pkg::*;
#(
    parameter int p_num_req     = 4,
    parameter int p_max_burst   = 16,
    parameter int p_hold_cycles = 4096,
    parameter int p_gap_cycles  = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [p_num_req-1:0]         i_req_valid,
    input  logic [8*p_num_req-1:0]       i_req_data,
    input  logic [p_num_req-1:0]         i_req_last,
    output logic [p_num_req-1:0]         o_req_ready,
    output logic [7:0]                   o_data,
    output logic                         o_valid,
    input  logic                         i_accept,
    output logic [$clog2(p_num_req)-1:0] o_grant_id,
    output logic                         o_busy
);

    localparam int IW       = $clog2(p_num_req);
    localparam int BW       = $clog2(p_max_burst + 1);
    localparam int HW       = $clog2(p_hold_cycles + 1);
    localparam int GW       = (p_gap_cycles > 0) ? $clog2(p_gap_cycles + 1) : 1;
    localparam int GAP_LAST = (p_gap_cycles > 0) ? p_gap_cycles - 1 : 0;

    state_e              r_state;
    logic [IW-1:0]       r_rr_ptr;
    logic                r_last_q;
    logic [BW-1:0]       r_burst_cnt;
    logic [HW-1:0]       r_hold_cnt;
    logic [GW-1:0]       r_gap_cnt;

    state_e              w_next_state;
    logic                w_found;
    logic [IW-1:0]       w_win_idx;
    logic                w_pop;
    logic [IW-1:0]       w_pop_idx;
    logic                w_release;
    logic [p_num_req-1:0] w_ready;
    byte_t               w_pop_byte;

    x_rr_pick #(.p_n(p_num_req)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_win_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_pop_idx    = o_grant_id;
        w_release    = 1'b0;
        w_ready      = '0;
        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_pop        = 1'b1;
                    w_pop_idx    = w_win_idx;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_accept) begin
                    if (r_last_q || (r_burst_cnt == BW'(p_max_burst))) begin
                        w_release = 1'b1;
                    end else if (i_req_valid[o_grant_id]) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            // A returning byte beats the timeout in the same cycle.
            ST_HOLD: begin
                if (i_req_valid[o_grant_id]) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SEND;
                end else if (r_hold_cnt == HW'(p_hold_cycles - 1)) begin
                    w_release = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GW'(GAP_LAST)) begin
                    w_next_state = ST_ARB;
                end
            end
            default: w_next_state = ST_ARB;
        endcase
        if (w_release) begin
            w_next_state = (p_gap_cycles > 0) ? ST_GAP : ST_ARB;
        end
        // Never pop a source while the arbiter is being reset.
        if (i_rst) begin
            w_pop = 1'b0;
        end
        if (w_pop) begin
            w_ready[w_pop_idx] = 1'b1;
        end
    end

    assign w_pop_byte  = i_req_data[{w_pop_idx, 3'b000} +: 8];
    assign o_req_ready = w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ARB;
            r_rr_ptr    <= '0;
            r_last_q    <= 1'b0;
            r_burst_cnt <= '0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_grant_id  <= '0;
            o_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            o_busy  <= (w_next_state != ST_ARB);
            if (w_pop) begin
                o_valid     <= 1'b1;
                o_data      <= w_pop_byte;
                o_grant_id  <= w_pop_idx;
                r_last_q    <= i_req_last[w_pop_idx];
                r_burst_cnt <= (r_state == ST_ARB) ? BW'(1) : r_burst_cnt + 1'b1;
            end else if ((r_state == ST_SEND) && i_accept) begin
                o_valid <= 1'b0;
            end
            if (w_release) begin
                r_rr_ptr <= IW'(next_idx(int'(o_grant_id), p_num_req));
            end
            r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
            r_gap_cnt  <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

endmodule
